// File: rtl/usr_pkg.sv
// ----------------------------------------------------------------------------
// usr_pkg
//
// Shared definitions for the universal shift register:
//   mode_e         - 3-bit operation select, encodings match the `mode` port
//   state_e        - burst controller state
//   is_shift_mode  - true for the operations a burst may repeat (SHL..ASR)
// ----------------------------------------------------------------------------
package usr_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'd0,
      MODE_LOAD = 3'd1,
      MODE_SHL  = 3'd2,
      MODE_SHR  = 3'd3,
      MODE_ROL  = 3'd4,
      MODE_ROR  = 3'd5,
      MODE_ASR  = 3'd6,
      MODE_CLR  = 3'd7
   } mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   // Only the shift/rotate operations make sense repeated N times. HOLD, LOAD
   // and CLR are idempotent, so a burst of them is treated as no start at all.
   function automatic logic is_shift_mode(input mode_e m);
      return (m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR});
   endfunction

endpackage : usr_pkg

// File: rtl/usr_step_logic.sv
// ----------------------------------------------------------------------------
// usr_step_logic
//
// Purely combinational next-value computation for one register step. The
// top level shares this single instance between the single-step path and the
// burst path by choosing which operation to present on `op`.
//
// Ports:
//   q       in   WIDTH  current register contents
//   op      in   mode_e operation to apply
//   d       in   WIDTH  parallel load data
//   sin_l   in   1      serial bit entering at the MSB on SHR
//   sin_r   in   1      serial bit entering at the LSB on SHL
//   q_next  out  WIDTH  register contents after applying `op` once
// ----------------------------------------------------------------------------
module usr_step_logic
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  mode_e            op,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q_next
);

   always_comb begin
      // NOTE: q_next gets a value before the case so that no path through
      // the block leaves it unassigned, which would otherwise infer a latch.
      q_next = q;
      unique case (op)
         MODE_HOLD: q_next = q;
         MODE_LOAD: q_next = d;
         MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
         MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
         MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
         // Arithmetic right shift replicates the sign bit.
         MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
         MODE_CLR:  q_next = '0;
         default:   q_next = q;
      endcase
   end

endmodule : usr_step_logic

// File: rtl/univ_shift_reg.sv
// ----------------------------------------------------------------------------
// univ_shift_reg
//
// Parametrised universal shift register with single-step operation and a
// multi-cycle burst mode.
//
// Single step: with en=1 in IDLE, `mode` is applied once at the next edge.
// Burst: with start=1 in IDLE and a shift/rotate mode, the mode and count are
// latched and the operation is applied once per edge for `count` edges while
// busy=1. done pulses for one cycle after the last step. A start with count=0
// completes immediately (no shift, done pulses next cycle). A start with a
// non-shift mode is not a start; en is then evaluated as usual.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous active-high reset
//   en      in   1      single-step enable
//   mode    in   3      operation select (see usr_pkg::mode_e)
//   d       in   WIDTH  parallel load data
//   sin_l   in   1      serial input entering at MSB (SHR)
//   sin_r   in   1      serial input entering at LSB (SHL)
//   start   in   1      begin a burst of `count` steps of `mode`
//   count   in   CNT_W  burst length in steps
//   q       out  WIDTH  register contents
//   sout_l  out  1      q[WIDTH-1]
//   sout_r  out  1      q[0]
//   busy    out  1      burst in progress
//   done    out  1      one-cycle pulse after the final burst step
// ----------------------------------------------------------------------------
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   mode_e            op_q, op_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             done_q, done_d;

   mode_e            mode_in;
   mode_e            step_op;
   logic [WIDTH-1:0] q_next;
   logic             start_ok;

   assign mode_in = mode_e'(mode);

   // A start is only a start when the requested operation is a shift/rotate.
   assign start_ok = start && is_shift_mode(mode_in);

   // The step logic is shared: during a burst it executes the latched op,
   // otherwise it executes whatever is on the mode port. Selecting here, in
   // its own statement, keeps the next-state block free of a path from its
   // own output back to its input.
   assign step_op = (state_q == ST_BURST) ? op_q : mode_in;

   usr_step_logic #(
      .WIDTH (WIDTH)
   ) u_step (
      .q      (q_q),
      .op     (step_op),
      .d      (d),
      .sin_l  (sin_l),
      .sin_r  (sin_r),
      .q_next (q_next)
   );

   // -------------------------------------------------------------------------
   // Next-state / datapath control
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      op_d        = op_q;
      q_d         = q_q;
      done_d      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               // Accepting a start never moves q on the accepting edge; the
               // first shift happens on the following edge.
               if (count != '0) begin
                  state_d     = ST_BURST;
                  remaining_d = count;
                  op_d        = mode_in;
               end else begin
                  done_d = 1'b1;
               end
            end else if (en) begin
               q_d = q_next;
            end
         end

         ST_BURST: begin
            // en, start, mode and count are deliberately not looked at here.
            q_d         = q_next;
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               op_d    = MODE_HOLD;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         op_q        <= MODE_HOLD;
         q_q         <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         op_q        <= op_d;
         q_q         <= q_d;
         done_q      <= done_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign q      = q_q;
   assign sout_l = q_q[WIDTH-1];
   assign sout_r = q_q[0];
   assign busy   = (state_q == ST_BURST);
   assign done   = done_q;

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_univ_shift_reg
//
// Directed-vector bench for univ_shift_reg (WIDTH=8, CNT_W=4). Inputs change
// 1 time unit after a rising edge and outputs are sampled at the same point,
// well away from the next active edge.
// ----------------------------------------------------------------------------
module tb_univ_shift_reg;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   localparam logic [2:0] M_HOLD = 3'd0;
   localparam logic [2:0] M_LOAD = 3'd1;
   localparam logic [2:0] M_SHL  = 3'd2;
   localparam logic [2:0] M_SHR  = 3'd3;
   localparam logic [2:0] M_ROL  = 3'd4;
   localparam logic [2:0] M_ROR  = 3'd5;
   localparam logic [2:0] M_ASR  = 3'd6;
   localparam logic [2:0] M_CLR  = 3'd7;

   logic             clk;
   logic             rst;
   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin_l;
   logic             sin_r;
   logic             start;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] q;
   logic             sout_l;
   logic             sout_r;
   logic             busy;
   logic             done;

   int n_vec  = 0;
   int n_miss = 0;

   univ_shift_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .d      (d),
      .sin_l  (sin_l),
      .sin_r  (sin_r),
      .start  (start),
      .count  (count),
      .q      (q),
      .sout_l (sout_l),
      .sout_r (sout_r),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge, landing 1 unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en    = 1'b0;
      mode  = M_HOLD;
      start = 1'b0;
      count = '0;
      sin_l = 1'b0;
      sin_r = 1'b0;
   endtask

   task automatic load(input logic [WIDTH-1:0] val);
      idle_inputs();
      en   = 1'b1;
      mode = M_LOAD;
      d    = val;
      step();
      en   = 1'b0;
      mode = M_HOLD;
   endtask

   // Single-step with en and check the resulting q.
   task automatic single(input string tag, input logic [2:0] m,
                         input logic sr, input logic [WIDTH-1:0] exp_q);
      en    = 1'b1;
      mode  = m;
      sin_r = sr;
      step();
      en    = 1'b0;
      mode  = M_HOLD;
      check(tag, 32'(q), 32'(exp_q));
   endtask

   initial begin
      rst = 1'b1;
      d   = '0;
      idle_inputs();

      // ---------------- reset state ----------------
      #2;
      check("rst_q",    32'(q),    32'h00);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      step();
      step();
      rst = 1'b0;

      // ---------------- LOAD then async reset mid-cycle ----------------
      load(8'hA5);
      check("load_a5", 32'(q), 32'hA5);
      #3 rst = 1'b1;
      #1;
      check("async_rst_q",    32'(q),    32'h00);
      check("async_rst_busy", 32'(busy), 32'h0);
      #2 rst = 1'b0;
      step();

      // ---------------- single steps from 0x81 ----------------
      load(8'h81);
      check("sout_l_81", 32'(sout_l), 32'h1);
      check("sout_r_81", 32'(sout_r), 32'h1);
      single("rol",     M_ROL, 1'b0, 8'h03);
      single("ror",     M_ROR, 1'b0, 8'h81);
      single("asr",     M_ASR, 1'b0, 8'hC0);
      check("sout_r_c0", 32'(sout_r), 32'h0);
      single("shl_sr1", M_SHL, 1'b1, 8'h81);
      single("clr",     M_CLR, 1'b0, 8'h00);
      single("hold",    M_HOLD, 1'b0, 8'h00);

      // ---------------- burst SHL x3 from 0x01 ----------------
      load(8'h01);
      mode  = M_SHL;
      count = 4'd3;
      start = 1'b1;
      sin_r = 1'b0;
      step();                                   // edge T
      start = 1'b0;
      mode  = M_HOLD;
      check("b3_accept_q",    32'(q),    32'h01);
      check("b3_accept_busy", 32'(busy), 32'h1);
      step();                                   // T+1
      check("b3_s1_q",    32'(q),    32'h02);
      check("b3_s1_busy", 32'(busy), 32'h1);
      check("b3_s1_done", 32'(done), 32'h0);
      step();                                   // T+2
      check("b3_s2_q",    32'(q),    32'h04);
      check("b3_s2_busy", 32'(busy), 32'h1);
      step();                                   // T+3
      check("b3_end_q",    32'(q),    32'h08);
      check("b3_end_busy", 32'(busy), 32'h0);
      check("b3_end_done", 32'(done), 32'h1);
      step();                                   // T+4
      check("b3_after_done", 32'(done), 32'h0);
      check("b3_after_q",    32'(q),    32'h08);

      // ---------------- burst ROR x12 from 0xF0, en/LOAD noise ----------------
      load(8'hF0);
      mode  = M_ROR;
      count = 4'd12;
      start = 1'b1;
      step();                                   // edge T
      start = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         en   = i[0];
         mode = M_LOAD;
         d    = 8'hFF;
         step();
         if (i < 12) check($sformatf("b12_busy_%0d", i), 32'(busy), 32'h1);
      end
      en   = 1'b0;
      mode = M_HOLD;
      check("b12_q",    32'(q),    32'h0F);
      check("b12_busy", 32'(busy), 32'h0);
      check("b12_done", 32'(done), 32'h1);
      step();
      check("b12_after_done", 32'(done), 32'h0);
      check("b12_after_q",    32'(q),    32'h0F);

      // ---------------- start+en, SHR count 0 ----------------
      en    = 1'b1;
      start = 1'b1;
      mode  = M_SHR;
      count = 4'd0;
      sin_l = 1'b1;
      step();
      en    = 1'b0;
      start = 1'b0;
      check("c0_q",    32'(q),    32'h0F);
      check("c0_busy", 32'(busy), 32'h0);
      check("c0_done", 32'(done), 32'h1);
      step();
      check("c0_after_done", 32'(done), 32'h0);
      check("c0_after_q",    32'(q),    32'h0F);

      // ---------------- start with LOAD: not a start, en loads ----------------
      en    = 1'b1;
      start = 1'b1;
      mode  = M_LOAD;
      count = 4'd5;
      d     = 8'h3C;
      step();
      en    = 1'b0;
      start = 1'b0;
      mode  = M_HOLD;
      check("ld_start_q",    32'(q),    32'h3C);
      check("ld_start_busy", 32'(busy), 32'h0);

      // ---------------- burst SHR x5, reset after 2 steps ----------------
      mode  = M_SHR;
      count = 4'd5;
      sin_l = 1'b1;
      start = 1'b1;
      step();                                   // edge T
      start = 1'b0;
      mode  = M_HOLD;
      check("ab_accept_busy", 32'(busy), 32'h1);
      step();
      check("ab_s1_q", 32'(q), 32'h9E);
      step();
      check("ab_s2_q", 32'(q), 32'hCF);
      #3 rst = 1'b1;
      #1;
      check("ab_rst_q",    32'(q),    32'h00);
      check("ab_rst_busy", 32'(busy), 32'h0);
      check("ab_rst_done", 32'(done), 32'h0);
      #2 rst = 1'b0;
      step();
      check("ab_post_done", 32'(done), 32'h0);
      check("ab_post_busy", 32'(busy), 32'h0);
      step();
      check("ab_post2_done", 32'(done), 32'h0);

      // ---------------- new burst after abort: SHR x2, sin_l=1 ----------------
      mode  = M_SHR;
      count = 4'd2;
      sin_l = 1'b1;
      start = 1'b1;
      step();                                   // edge T
      start = 1'b0;
      mode  = M_HOLD;
      check("nb_accept_busy", 32'(busy), 32'h1);
      step();
      check("nb_s1_q", 32'(q), 32'h80);
      step();
      check("nb_end_q",    32'(q),    32'hC0);
      check("nb_end_busy", 32'(busy), 32'h0);
      check("nb_end_done", 32'(done), 32'h1);
      check("nb_sout_l",   32'(sout_l), 32'h1);
      step();
      check("nb_after_done", 32'(done), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_univ_shift_reg
